// File: rtl/regfile_write_scheduler.sv
// Write-port owner for the register file: init sweep, then core/debug arbitration.
// Latency: one cycle from accepted request (or sweep step) to rf_* pulse.
// Backpressure: core_stall / dbg_ready combinational; debug forced through after STARVE_LIMIT losses.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   init_start                          pulse in RUN -> restart init sweep next cycle
//   core_we/core_rd/core_wdata          core writeback request; core_stall holds it off
//   dbg_valid/dbg_rd/dbg_wdata          debug write request; dbg_ready completes handshake
//   rf_RegWrite/rf_Rd/rf_Write_data     registered register-file write port
//   init_busy                           registered, high while the sweep runs
module regfile_write_scheduler #(
    parameter int                NUM_REGS     = 32,
    parameter int                ADDR_W       = 5,
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
    parameter int                STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_rd,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_rd,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic              rf_RegWrite,
    output logic [ADDR_W-1:0] rf_Rd,
    output logic [DATA_W-1:0] rf_Write_data,
    output logic              init_busy
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        starve_q, starve_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              busy_q, busy_d;

    logic              dbg_win;
    logic              core_win;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        busy_d     = busy_q;
        core_stall = 1'b0;
        dbg_ready  = 1'b0;
        dbg_win    = 1'b0;
        core_win   = 1'b0;
        win_rd     = core_rd;
        win_data   = core_wdata;

        case (state_q)
            ST_INIT: begin
                // Sweep owns the port; requesters wait and init_start is ignored.
                core_stall = core_we;
                starve_d   = '0;
                rf_we_d    = 1'b1;
                rf_rd_d    = idx_q;
                rf_data_d  = (idx_q == '0) ? '0 : INIT_VALUE;
                idx_d      = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                // Debug takes the port when core is idle or debug has starved long enough.
                dbg_ready  = !core_we || (starve_q == STARVE_MAX);
                dbg_win    = dbg_valid && dbg_ready;
                core_win   = core_we && !dbg_win;
                core_stall = core_we && dbg_win;

                if (dbg_win) begin
                    win_rd   = dbg_rd;
                    win_data = dbg_wdata;
                end

                // Writes to register 0 complete the handshake but never reach the file.
                if ((dbg_win || core_win) && (win_rd != '0)) begin
                    rf_we_d   = 1'b1;
                    rf_rd_d   = win_rd;
                    rf_data_d = win_data;
                end

                if (dbg_valid && !dbg_win) begin
                    starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
                end else begin
                    starve_d = '0;
                end

                // The write accepted this cycle still issues; the sweep follows it.
                if (init_start) begin
                    state_d  = ST_INIT;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    starve_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            idx_q     <= '0;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_RegWrite   = rf_we_q;
    assign rf_Rd         = rf_rd_q;
    assign rf_Write_data = rf_data_q;
    assign init_busy     = busy_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_start;
    logic              core_we;
    logic [ADDR_W-1:0] core_rd;
    logic [DATA_W-1:0] core_wdata;
    logic              core_stall;
    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_rd;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ready;
    logic              rf_RegWrite;
    logic [ADDR_W-1:0] rf_Rd;
    logic [DATA_W-1:0] rf_Write_data;
    logic              init_busy;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    regfile_write_scheduler #(
        .NUM_REGS    (32),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .INIT_VALUE  (32'd1),
        .STARVE_LIMIT(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_start   (init_start),
        .core_we      (core_we),
        .core_rd      (core_rd),
        .core_wdata   (core_wdata),
        .core_stall   (core_stall),
        .dbg_valid    (dbg_valid),
        .dbg_rd       (dbg_rd),
        .dbg_wdata    (dbg_wdata),
        .dbg_ready    (dbg_ready),
        .rf_RegWrite  (rf_RegWrite),
        .rf_Rd        (rf_Rd),
        .rf_Write_data(rf_Write_data),
        .init_busy    (init_busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rf write pulse must match the oldest expected write.
    always @(posedge clk) begin
        #2;
        if (rst_n && rf_RegWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write_unexpected: got rd=%0d data=%h, required no write", rf_Rd, rf_Write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_Rd !== mon_e.rd || rf_Write_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL rf_write: got rd=%0d data=%h, required rd=%0d data=%h",
                             rf_Rd, rf_Write_data, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    task automatic push_sweep;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back('{rd: ADDR_W'(i), data: (i == 0) ? 32'd0 : 32'd1});
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; core_we = 1'b1; core_rd = 5'd4; core_wdata = 32'hAAAA_0000;
        @(negedge clk);
        checks++;
        if (rf_RegWrite !== 1'b0 || rf_Rd !== '0 || rf_Write_data !== '0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: we=%b rd=%0d data=%h busy=%b, required 0 0 0 1",
                     rf_RegWrite, rf_Rd, rf_Write_data, init_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_sweep();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if (rf_RegWrite !== 1'b1) begin
                errors++;
                $display("FAIL sweep_we[%0d]: got %b, required 1", i, rf_RegWrite);
            end
            checks++;
            if (init_busy !== (i != 31)) begin
                errors++;
                $display("FAIL sweep_busy[%0d]: got %b, required %b", i, init_busy, i != 31);
            end
            checks++;
            if (core_stall !== (i != 31)) begin
                errors++;
                $display("FAIL sweep_core_stall[%0d]: got %b, required %b", i, core_stall, i != 31);
            end
        end
        core_we = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end_we: got %b, required 0", rf_RegWrite);
        end
        check_drained("reset");
    endtask

    task automatic test_core_write;
        core_we = 1'b1; core_rd = 5'd5; core_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (core_stall !== 1'b0) begin
            errors++;
            $display("FAIL core_stall: got %b, required 0", core_stall);
        end
        exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
        @(negedge clk);
        core_we = 1'b0;
        checks++;
        if (rf_RegWrite !== 1'b1 || rf_Rd !== 5'd5) begin
            errors++;
            $display("FAIL core_latency: we=%b rd=%0d, required 1 5", rf_RegWrite, rf_Rd);
        end
        @(negedge clk);
        checks++;
        if (rf_RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL core_pulse: got %b, required 0", rf_RegWrite);
        end
        check_drained("core");
    endtask

    task automatic test_starve;
        core_we = 1'b1; core_rd = 5'd9;
        dbg_rd = 5'd3; dbg_wdata = 32'h1234;
        for (int c = 1; c <= 6; c++) begin
            core_wdata = 32'(c);
            dbg_valid  = (c <= 5);
            #1;
            if (c <= 5) begin
                checks++;
                if (dbg_ready !== (c == 5)) begin
                    errors++;
                    $display("FAIL starve_dbg_ready[%0d]: got %b, required %b", c, dbg_ready, c == 5);
                end
            end
            checks++;
            if (core_stall !== (c == 5)) begin
                errors++;
                $display("FAIL starve_core_stall[%0d]: got %b, required %b", c, core_stall, c == 5);
            end
            if (c == 5) exp_q.push_back('{rd: 5'd3, data: 32'h1234});
            else        exp_q.push_back('{rd: 5'd9, data: 32'(c)});
            @(negedge clk);
        end
        core_we = 1'b0; dbg_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_drained("starve");
    endtask

    task automatic test_reg0;
        core_we = 1'b1; core_rd = 5'd0; core_wdata = 32'hFFFF;
        #1;
        checks++;
        if (core_stall !== 1'b0) begin
            errors++;
            $display("FAIL reg0_core_stall: got %b, required 0", core_stall);
        end
        @(negedge clk);
        core_we = 1'b0;
        checks++;
        if (rf_RegWrite !== 1'b0 || rf_Rd !== 5'd9 || rf_Write_data !== 32'd6) begin
            errors++;
            $display("FAIL reg0_core_hold: we=%b rd=%0d data=%h, required 0 9 6", rf_RegWrite, rf_Rd, rf_Write_data);
        end
        dbg_valid = 1'b1; dbg_rd = 5'd0; dbg_wdata = 32'hBEEF;
        #1;
        checks++;
        if (dbg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reg0_dbg_ready: got %b, required 1", dbg_ready);
        end
        @(negedge clk);
        dbg_valid = 1'b0;
        checks++;
        if (rf_RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL reg0_dbg_we: got %b, required 0", rf_RegWrite);
        end
        check_drained("reg0");
    endtask

    task automatic test_init_start;
        init_start = 1'b1; core_we = 1'b1; core_rd = 5'd7; core_wdata = 32'h77;
        #1;
        checks++;
        if (core_stall !== 1'b0) begin
            errors++;
            $display("FAIL init_start_core_stall: got %b, required 0", core_stall);
        end
        exp_q.push_back('{rd: 5'd7, data: 32'h77});
        push_sweep();
        @(negedge clk);
        init_start = 1'b0; core_we = 1'b0;
        dbg_valid = 1'b1; dbg_rd = 5'd2; dbg_wdata = 32'h55;
        checks++;
        if (rf_RegWrite !== 1'b1 || rf_Rd !== 5'd7 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL init_start_first: we=%b rd=%0d busy=%b, required 1 7 1", rf_RegWrite, rf_Rd, init_busy);
        end
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++;
            if (dbg_ready !== 1'b0) begin
                errors++;
                $display("FAIL init_dbg_ready[%0d]: got %b, required 0", i, dbg_ready);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (dbg_ready !== 1'b1 || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_done: dbg_ready=%b busy=%b, required 1 0", dbg_ready, init_busy);
        end
        exp_q.push_back('{rd: 5'd2, data: 32'h55});
        @(negedge clk);
        dbg_valid = 1'b0;
        @(negedge clk);
        check_drained("init_start");
    endtask

    task automatic test_reset_mid;
        int budget;
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        push_sweep();
        budget = 0;
        while (!(rf_RegWrite === 1'b1 && rf_Rd === 5'd10) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (budget >= 50) begin
            errors++;
            $display("FAIL mid_reach_idx10: rd=%0d, required 10 within 50 cycles", rf_Rd);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_RegWrite !== 1'b0 || rf_Rd !== '0 || rf_Write_data !== '0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_state: we=%b rd=%0d data=%h busy=%b, required 0 0 0 1",
                     rf_RegWrite, rf_Rd, rf_Write_data, init_busy);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_sweep();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if (rf_RegWrite !== 1'b1) begin
                errors++;
                $display("FAIL mid_sweep_we[%0d]: got %b, required 1", i, rf_RegWrite);
            end
        end
        @(negedge clk);
        checks++;
        if (init_busy !== 1'b0 || rf_RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_end: busy=%b we=%b, required 0 0", init_busy, rf_RegWrite);
        end
        check_drained("reset_mid");
    endtask

    initial begin
        rst_n = 1'b0; init_start = 1'b0;
        core_we = 1'b0; core_rd = '0; core_wdata = '0;
        dbg_valid = 1'b0; dbg_rd = '0; dbg_wdata = '0;
        test_reset();
        test_core_write();
        test_starve();
        test_reg0();
        test_init_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
